rdata_aligner: RTL and testbench

//  Read-side companion of the DMA write aligner. Fetches aligned DATA_W beats over the DMA read channel
//  and returns a sequential stream of unaligned DATA_W words to a databus consumer.
//  The stream covers the byte range [startAddr, endAddr]. Byte startAddr lands in dbus_rdata[7:0] (little-endian).

---
 rtl/rdata_aligner_pkg.sv | 17 +
 rtl/rdata_byte_shifter.sv | 16 +
 rtl/rdata_aligner.sv | 196 +++++++++++++++++++
 tb/tb_rdata_aligner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rdata_aligner_pkg.sv
// Shared definitions for the read-side DMA aligner: FSM state codes and burst length width.
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

package rdata_aligner_pkg;

    localparam int AXI_LEN_W = `AXI_LEN_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rdata_byte_shifter.sv
// Combinational byte shifter: selects DATA_W bits out of a 2*DATA_W window, starting at byte off.
module rdata_byte_shifter #(
    parameter int DATA_W   = 32,
    parameter int OFFSET_W = 2
) (
    input  logic [2*DATA_W-1:0] window,
    input  logic [OFFSET_W-1:0] off,
    output logic [DATA_W-1:0]   data
);

    logic [2*DATA_W-1:0] shifted;

    assign shifted = window >> {off, 3'b000};
    assign data    = shifted[DATA_W-1:0];

endmodule

// File: rtl/rdata_aligner.sv
// Read aligner: fetches aligned DMA beats and returns an unaligned little-endian word stream.
// Optional build macro RDATA_ALIGN_ZERO_FILL_EN zeroes bytes past endAddr in the final word.
module rdata_aligner
    import rdata_aligner_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  run,
    input  logic [ADDR_W-1:0]     startAddr,
    input  logic [ADDR_W-1:0]     endAddr,
    output logic                  done,
    input  logic                  dbus_valid,
    output logic [DATA_W-1:0]     dbus_rdata,
    output logic                  dbus_ready,
    output logic                  dma_r_valid,
    output logic [ADDR_W-1:0]     dma_r_addr,
    output logic [`AXI_LEN_W-1:0] dma_r_len,
    input  logic [DATA_W-1:0]     dma_r_rdata,
    input  logic                  dma_r_ready
);

    localparam int BYTES    = DATA_W / 8;
    localparam int OFFSET_W = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] MAX_BEATS  = ADDR_W'(1) << AXI_LEN_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    state_t                state_reg;
    logic [ADDR_W-1:0]     start_reg, end_reg;
    logic [ADDR_W-1:0]     beats_reg, words_reg;
    logic [OFFSET_W-1:0]   off_reg;
    logic [DATA_W-1:0]     b0_reg, b1_reg, b0_next, b1_next;
    logic                  v0_reg, v1_reg, v0_next, v1_next;
    logic [AXI_LEN_W-1:0]  burst_cnt_reg, len_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic                  done_reg;

    logic [ADDR_W-1:0]     diff, cfg_beats, cfg_words, beats_m1;
    logic                  active, word_avail, deliver, accept;
    logic [DATA_W-1:0]     shifted;

    function automatic logic [AXI_LEN_W-1:0] burst_len(input logic [ADDR_W-1:0] beats);
        return (beats > MAX_BEATS) ? '1 : AXI_LEN_W'(beats - ONE);
    endfunction

    assign diff      = end_reg - start_reg;
    assign cfg_beats = (end_reg >> OFFSET_W) - (start_reg >> OFFSET_W) + ONE;
    assign cfg_words = (diff >> OFFSET_W) + ONE;
    assign beats_m1  = beats_reg - ONE;

    // An unaligned word needs the following beat too, unless no further beat exists.
    assign active      = (state_reg == ST_STREAM) && !clear;
    assign word_avail  = v0_reg && (off_reg == '0 || v1_reg || beats_reg == '0);
    assign deliver     = active && dbus_valid && word_avail;
    assign dma_r_valid = active && (beats_reg != '0) && (deliver || !v1_reg);
    assign accept      = dma_r_valid && dma_r_ready;

    assign dbus_ready = deliver;
    assign done       = done_reg;
    assign dma_r_addr = addr_reg;
    assign dma_r_len  = len_reg;

    always_comb begin
        b0_next = deliver ? b1_reg : b0_reg;
        v0_next = deliver ? v1_reg : v0_reg;
        b1_next = deliver ? '0 : b1_reg;
        v1_next = deliver ? 1'b0 : v1_reg;
        if (accept) begin
            if (!v0_next) begin
                b0_next = dma_r_rdata;
                v0_next = 1'b1;
            end else begin
                b1_next = dma_r_rdata;
                v1_next = 1'b1;
            end
        end
    end

    rdata_byte_shifter #(
        .DATA_W   (DATA_W),
        .OFFSET_W (OFFSET_W)
    ) u_shifter (
        .window ({b1_reg, b0_reg}),
        .off    (off_reg),
        .data   (shifted)
    );

`ifdef RDATA_ALIGN_ZERO_FILL_EN
    logic [OFFSET_W-1:0] last_byte_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_byte_reg <= '0;
        end else if (state_reg == ST_CONFIG) begin
            last_byte_reg <= diff[OFFSET_W-1:0];
        end
    end

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_fill
        assign dbus_rdata[8*gi +: 8] = (words_reg == ONE && OFFSET_W'(gi) > last_byte_reg)
                                       ? 8'h00 : shifted[8*gi +: 8];
    end
`else
    assign dbus_rdata = shifted;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            start_reg     <= '0;
            end_reg       <= '0;
            beats_reg     <= '0;
            words_reg     <= '0;
            off_reg       <= '0;
            b0_reg        <= '0;
            b1_reg        <= '0;
            v0_reg        <= 1'b0;
            v1_reg        <= 1'b0;
            burst_cnt_reg <= '0;
            len_reg       <= '0;
            addr_reg      <= '0;
            done_reg      <= 1'b0;
        end else if (clear) begin
            state_reg <= ST_IDLE;
            beats_reg <= '0;
            words_reg <= '0;
            b0_reg    <= '0;
            b1_reg    <= '0;
            v0_reg    <= 1'b0;
            v1_reg    <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            b0_reg   <= b0_next;
            b1_reg   <= b1_next;
            v0_reg   <= v0_next;
            v1_reg   <= v1_next;
            case (state_reg)
                ST_IDLE: begin
                    if (run) begin
                        start_reg <= startAddr;
                        end_reg   <= endAddr;
                        state_reg <= ST_CONFIG;
                    end
                end
                ST_CONFIG: begin
                    beats_reg <= cfg_beats;
                    words_reg <= cfg_words;
                    off_reg   <= start_reg[OFFSET_W-1:0];
                    if (end_reg < start_reg) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        addr_reg      <= start_reg & ALIGN_MASK;
                        len_reg       <= burst_len(cfg_beats);
                        burst_cnt_reg <= burst_len(cfg_beats);
                        state_reg     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        beats_reg <= beats_m1;
                        // Last beat of the burst: move the window and size the next burst.
                        if (burst_cnt_reg == '0) begin
                            addr_reg      <= addr_reg + ((ADDR_W'(len_reg) + ONE) << OFFSET_W);
                            len_reg       <= burst_len(beats_m1);
                            burst_cnt_reg <= burst_len(beats_m1);
                        end else begin
                            burst_cnt_reg <= burst_cnt_reg - 1'b1;
                        end
                    end
                    if (deliver) begin
                        words_reg <= words_reg - ONE;
                        if (words_reg == ONE) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    b0_reg    <= '0;
                    b1_reg    <= '0;
                    v0_reg    <= 1'b0;
                    v1_reg    <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rdata_aligner.sv
// Directed testbench for rdata_aligner; memory byte at address A reads as A[7:0].
`timescale 1ns/1ps
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module tb_rdata_aligner;

    logic                  clk = 1'b0;
    logic                  rst, clear, run;
    logic [31:0]           startAddr, endAddr;
    logic                  done;
    logic                  dbus_valid;
    logic [31:0]           dbus_rdata;
    logic                  dbus_ready;
    logic                  dma_r_valid;
    logic [31:0]           dma_r_addr;
    logic [`AXI_LEN_W-1:0] dma_r_len;
    logic [31:0]           dma_r_rdata;
    logic                  dma_r_ready;

    always #5 clk = ~clk;

    rdata_aligner #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .run         (run),
        .startAddr   (startAddr),
        .endAddr     (endAddr),
        .done        (done),
        .dbus_valid  (dbus_valid),
        .dbus_rdata  (dbus_rdata),
        .dbus_ready  (dbus_ready),
        .dma_r_valid (dma_r_valid),
        .dma_r_addr  (dma_r_addr),
        .dma_r_len   (dma_r_len),
        .dma_r_rdata (dma_r_rdata),
        .dma_r_ready (dma_r_ready)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cur_start, cur_end;
    int          exp_beats_total, word_idx, beats_taken, beat_cnt, cur_len;
    int          bursts_seen, done_cnt, cyc;
    logic [31:0] first_word, last_word, s_rdata;
    logic        s_dma_valid, s_dbus_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] w, a;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            a = cur_start + 32'(4 * k + b);
            if (a <= cur_end) w[8*b +: 8] = a[7:0];
`ifndef RDATA_ALIGN_ZERO_FILL_EN
            else if ((a >> 2) == (cur_end >> 2)) w[8*b +: 8] = a[7:0];
`endif
        end
        return w;
    endfunction

    task automatic setup(input logic [31:0] s, input logic [31:0] e);
        cur_start = s;
        cur_end   = e;
        startAddr = s;
        endAddr   = e;
        exp_beats_total = (e < s) ? 0 : int'((e >> 2) - (s >> 2)) + 1;
        word_idx = 0; beats_taken = 0; beat_cnt = 0; cur_len = 0;
        bursts_seen = 0; done_cnt = 0;
    endtask

    // One clock: drive at negedge, sample 1 ns before the next posedge.
    task automatic cycle(input logic dv, input logic rr, input logic rn, input logic clr);
        logic [31:0] a;
        int          remaining;
        @(negedge clk);
        dbus_valid  = dv;
        dma_r_ready = rr;
        run         = rn;
        clear       = clr;
        a = dma_r_addr + 32'(4 * beat_cnt);
        dma_r_rdata = {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
        #4;
        s_dma_valid  = dma_r_valid;
        s_dbus_ready = dbus_ready;
        s_rdata      = dbus_rdata;
        if (dma_r_valid && dma_r_ready) begin
            if (beat_cnt == 0) begin
                remaining = exp_beats_total - beats_taken;
                cur_len   = (remaining > 256) ? 255 : remaining - 1;
                check("burst_addr", dma_r_addr, (cur_start & ~32'h3) + 32'(4 * beats_taken));
                check("burst_len", dma_r_len, cur_len);
                bursts_seen++;
                $display("burst addr=0x%08h len=%0d", dma_r_addr, dma_r_len);
            end
            beats_taken++;
            if (beat_cnt == cur_len) beat_cnt = 0;
            else beat_cnt++;
        end
        if (dbus_ready) begin
            $display("word %0d rdata=0x%08h", word_idx, dbus_rdata);
            check("word", dbus_rdata, exp_word(word_idx));
            if (word_idx == 0) first_word = dbus_rdata;
            last_word = dbus_rdata;
            word_idx++;
        end
        if (done) done_cnt++;
        cyc++;
        @(posedge clk);
    endtask

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] e, input int stall_at,
                            input int stall_len, input bit gaps);
        int   stall_left, guard, exp_words;
        logic dv;
        setup(s, e);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        stall_left = stall_len;
        guard      = 0;
        while (done_cnt == 0 && guard < 5000) begin
            dv = 1'b1;
            if (word_idx == stall_at && stall_left > 0) begin
                dv = 1'b0;
                stall_left--;
            end
            cycle(dv, gaps ? logic'(cyc % 3 != 2) : 1'b1, 1'b0, 1'b0);
            if (stall_len > 0 && !dv && stall_left == stall_len - 15)
                check("stall_dma_valid_low", s_dma_valid, 1'b0);
            guard++;
        end
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        exp_words = (e < s) ? 0 : int'((e - s) >> 2) + 1;
        check("done_pulses", done_cnt, 1);
        check("word_count", word_idx, exp_words);
        check("beat_count", beats_taken, exp_beats_total);
        check("burst_count", bursts_seen, (exp_beats_total + 255) / 256);
    endtask

    initial begin
        logic [31:0] exp_tail;
        rst = 1'b1; clear = 1'b0; run = 1'b0; dbus_valid = 1'b0;
        dma_r_ready = 1'b0; dma_r_rdata = '0; startAddr = '0; endAddr = '0;
        cyc = 0;
        setup(32'h0, 32'h0);

        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_dma_valid", s_dma_valid, 1'b0);
        check("rst_dbus_ready", s_dbus_ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rdata", s_rdata, 32'h0);
        check("rst_dma_addr", dma_r_addr, 32'h0);
        check("rst_dma_len", dma_r_len, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: aligned, single burst
        run_xfer(32'h100, 32'h10F, -1, 0, 1'b0);
        check("t1_first", first_word, 32'h03020100);
        check("t1_last", last_word, 32'h0F0E0D0C);

        // 2: unaligned start spanning three beats
        run_xfer(32'h101, 32'h108, -1, 0, 1'b0);
        check("t2_first", first_word, 32'h04030201);
        check("t2_last", last_word, 32'h08070605);

        // 3: single byte
        run_xfer(32'h103, 32'h103, -1, 0, 1'b0);
        check("t3_word", first_word, 32'h00000003);

        // unaligned tail inside the final beat
        run_xfer(32'h101, 32'h106, -1, 0, 1'b1);
`ifdef RDATA_ALIGN_ZERO_FILL_EN
        exp_tail = 32'h00000605;
`else
        exp_tail = 32'h00070605;
`endif
        check("tail_word", last_word, exp_tail);

        // empty range: no DMA activity, still a done pulse
        run_xfer(32'h110, 32'h10F, -1, 0, 1'b0);

        // 4: 300 beats split into 256 + 44
        run_xfer(32'h000, 32'h4AF, -1, 0, 1'b0);
        check("t4_last", last_word, 32'hAFAEADAC);

        // 5: consumer stalls 20 cycles mid-stream, DMA with ready gaps
        run_xfer(32'h302, 32'h37F, 5, 20, 1'b1);
        check("t5_first", first_word, 32'h05040302);
        check("t5_last", last_word, 32'h00007F7E);

        // 6: clear mid-stream
        setup(32'h200, 32'h23F);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 200 && word_idx < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_dma_valid", s_dma_valid, 1'b0);
        check("clr_dbus_ready", s_dbus_ready, 1'b0);
        check("clr_rdata", s_rdata, 32'h0);
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_no_done", done_cnt, 0);
        check("clr_words", word_idx, 3);
        run_xfer(32'h100, 32'h10F, -1, 0, 1'b0);
        check("post_clr_first", first_word, 32'h03020100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
